// File: rtl/imem_loader.sv
// imem_loader: boot-time loader that turns a byte stream (16-bit little-endian
// word count followed by little-endian 32-bit words) into instruction-memory
// writes at word indices 0..count-1, holding the CPU fetch stage in reset
// until the final word has been written.
module imem_loader #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_LEN0  = 3'd0,
    S_LEN1  = 3'd1,
    S_DATA  = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_e;

  // Depth widened to the length width plus one so the overflow test never wraps.
  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  // Places one stream byte into the selected little-endian lane of a word.
  function automatic logic [31:0] put_lane(input logic [31:0] word,
                                           input logic [1:0]  lane,
                                           input logic [7:0]  byte_v);
    logic [31:0] res;
    res = word;
    case (lane)
      2'd0:    res[7:0]   = byte_v;
      2'd1:    res[15:8]  = byte_v;
      2'd2:    res[23:16] = byte_v;
      2'd3:    res[31:24] = byte_v;
      default: res        = word;
    endcase
    return res;
  endfunction

  state_e            state_q;
  logic [15:0]       len_q;
  logic [1:0]        byte_cnt_q;
  logic [ADDR_W:0]   word_idx_q;   // one extra bit so index == DEPTH is representable
  logic [31:0]       word_q;
  logic              in_ready_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic              cpu_hold_q;
  logic              done_q;
  logic              err_q;

  logic              hs_d;
  logic [15:0]       len_full_d;
  logic [31:0]       word_d;
  logic              last_word_d;
  logic              len_zero_d;
  logic              len_over_d;

  // Handshake detection and the values the FSM commits on a handshake.
  always_comb begin
    hs_d        = in_valid && in_ready_q;
    len_full_d  = {in_data, len_q[7:0]};
    word_d      = put_lane(word_q, byte_cnt_q, in_data);
    last_word_d = (16'(word_idx_q) == (len_q - 16'd1));
    len_zero_d  = (len_full_d == 16'd0);
    len_over_d  = ({1'b0, len_full_d} > DEPTH_W);
  end

  // Loader FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_LEN0;
      len_q       <= 16'd0;
      byte_cnt_q  <= 2'd0;
      word_idx_q  <= '0;
      word_q      <= 32'd0;
      in_ready_q  <= 1'b1;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
      cpu_hold_q  <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      // Write strobe is a single-cycle pulse unless re-armed below.
      mem_we_q <= 1'b0;
      case (state_q)
        S_LEN0: begin
          if (hs_d) begin
            len_q[7:0] <= in_data;
            state_q    <= S_LEN1;
          end
        end

        S_LEN1: begin
          if (hs_d) begin
            len_q[15:8] <= in_data;
            if (len_zero_d) begin
              state_q    <= S_DONE;
              in_ready_q <= 1'b0;
              cpu_hold_q <= 1'b0;
              done_q     <= 1'b1;
            end else if (len_over_d) begin
              state_q    <= S_ERR;
              in_ready_q <= 1'b0;
              cpu_hold_q <= 1'b1;
              err_q      <= 1'b1;
            end else begin
              state_q <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (hs_d) begin
            word_q     <= word_d;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              mem_we_q    <= 1'b1;
              mem_addr_q  <= word_idx_q[ADDR_W-1:0];
              mem_wdata_q <= word_d;
              word_idx_q  <= word_idx_q + 1'b1;
              if (last_word_d) begin
                // Stop accepting bytes while the final write is in flight.
                state_q    <= S_FLUSH;
                in_ready_q <= 1'b0;
              end else begin
                state_q <= S_DATA;
              end
            end
          end
        end

        S_FLUSH: begin
          // The final write strobe is visible for this one cycle; release the CPU after it.
          state_q    <= S_DONE;
          in_ready_q <= 1'b0;
          cpu_hold_q <= 1'b0;
          done_q     <= 1'b1;
        end

        S_DONE: begin
          state_q    <= S_DONE;
          in_ready_q <= 1'b0;
          cpu_hold_q <= 1'b0;
          done_q     <= 1'b1;
        end

        S_ERR: begin
          state_q    <= S_ERR;
          in_ready_q <= 1'b0;
          cpu_hold_q <= 1'b1;
          err_q      <= 1'b1;
        end

        default: begin
          // An illegal encoding is treated as a failed load: keep the CPU held.
          state_q    <= S_ERR;
          in_ready_q <= 1'b0;
          cpu_hold_q <= 1'b1;
          err_q      <= 1'b1;
        end
      endcase
    end
  end

  // Output ports driven straight from their registers.
  always_comb begin
    in_ready  = in_ready_q;
    mem_we    = mem_we_q;
    mem_addr  = mem_addr_q;
    mem_wdata = mem_wdata_q;
    cpu_hold  = cpu_hold_q;
    done      = done_q;
    err       = err_q;
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader: drives byte streams and checks the
// write strobes, addresses, data and the hold/done/err flags.
module tb_imem_loader;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        err;

  int n_checks;
  int n_fail;

  // Write log filled by the monitor
  logic [7:0]  wr_addr_log [0:511];
  logic [31:0] wr_data_log [0:511];
  int          wr_n;
  int          dup_cnt;
  logic        prev_we;

  imem_loader #(.DEPTH(256), .ADDR_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every write strobe and count strobes lasting more than one cycle
  always @(negedge clk) begin
    if (mem_we) begin
      if (wr_n < 512) begin
        wr_addr_log[wr_n] = mem_addr;
        wr_data_log[wr_n] = mem_wdata;
      end
      wr_n = wr_n + 1;
      if (prev_we) dup_cnt = dup_cnt + 1;
    end
    prev_we = mem_we;
  end

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    wr_n = 0;
    dup_cnt = 0;
    prev_we = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: in_ready=%0b required 1 for byte %02h", in_ready, b);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    send_byte(w[7:0],   gap);
    send_byte(w[15:8],  gap);
    send_byte(w[23:16], gap);
    send_byte(w[31:24], gap);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    wr_n = 0; dup_cnt = 0; prev_we = 1'b0;
    #12;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %0b want 1", in_ready); end
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mem_we: got %0b want 0", mem_we); end
    n_checks++; if (mem_addr !== 8'h00) begin n_fail++; $display("FAIL rst_mem_addr: got %02h want 00", mem_addr); end
    n_checks++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL rst_mem_wdata: got %08h want 0", mem_wdata); end
    n_checks++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL rst_cpu_hold: got %0b want 1", cpu_hold); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %0b want 0", done); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %0b want 0", err); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    do_reset();
    send_byte(8'h02, 0); send_byte(8'h00, 0);
    n_checks++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL basic_hold_during: got %0b want 1", cpu_hold); end
    send_word(32'h0000_0001, 0);
    send_word(32'h0000_0002, 0);
    // Cycle right after the last byte: final write in flight, input closed
    n_checks++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL basic_flush_we: got %0b want 1", mem_we); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_flush_ready: got %0b want 0", in_ready); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_flush_done: got %0b want 0", done); end
    n_checks++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL basic_flush_hold: got %0b want 1", cpu_hold); end
    @(posedge clk); #1;
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL basic_done: got %0b want 1", done); end
    n_checks++; if (cpu_hold !== 1'b0) begin n_fail++; $display("FAIL basic_release: got %0b want 0", cpu_hold); end
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL basic_we_after: got %0b want 0", mem_we); end
    repeat (3) @(negedge clk);
    n_checks++; if (wr_n !== 2) begin n_fail++; $display("FAIL basic_wr_count: got %0d want 2", wr_n); end
    n_checks++; if (wr_addr_log[0] !== 8'd0 || wr_data_log[0] !== 32'h1) begin n_fail++; $display("FAIL basic_wr0: got %02h/%08h want 00/00000001", wr_addr_log[0], wr_data_log[0]); end
    n_checks++; if (wr_addr_log[1] !== 8'd1 || wr_data_log[1] !== 32'h2) begin n_fail++; $display("FAIL basic_wr1: got %02h/%08h want 01/00000002", wr_addr_log[1], wr_data_log[1]); end
  endtask

  task automatic test_zero_len();
    do_reset();
    send_byte(8'h00, 0); send_byte(8'h00, 0);
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL zero_done: got %0b want 1", done); end
    n_checks++; if (cpu_hold !== 1'b0) begin n_fail++; $display("FAIL zero_hold: got %0b want 0", cpu_hold); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL zero_ready: got %0b want 0", in_ready); end
    repeat (4) @(negedge clk);
    n_checks++; if (wr_n !== 0) begin n_fail++; $display("FAIL zero_no_write: got %0d want 0", wr_n); end
  endtask

  task automatic test_overflow();
    do_reset();
    send_byte(8'h01, 0); send_byte(8'h01, 0);
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL ovf_err: got %0b want 1", err); end
    n_checks++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL ovf_hold: got %0b want 1", cpu_hold); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL ovf_ready: got %0b want 0", in_ready); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL ovf_done: got %0b want 0", done); end
    repeat (4) @(negedge clk);
    n_checks++; if (wr_n !== 0) begin n_fail++; $display("FAIL ovf_no_write: got %0d want 0", wr_n); end
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %0b want 1", err); end
  endtask

  task automatic test_full_depth();
    int bad;
    do_reset();
    send_byte(8'h00, 0); send_byte(8'h01, 0);
    for (int i = 0; i < 256; i++) send_word(32'h1000_0000 + 32'(i), 0);
    @(posedge clk); #1;
    n_checks++; if (done !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL full_done: got done=%0b err=%0b want 1/0", done, err); end
    repeat (2) @(negedge clk);
    n_checks++; if (wr_n !== 256) begin n_fail++; $display("FAIL full_wr_count: got %0d want 256", wr_n); end
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (wr_addr_log[i] !== 8'(i) || wr_data_log[i] !== 32'h1000_0000 + 32'(i)) bad++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL full_contents: got %0d bad entries want 0", bad); end
    n_checks++; if (wr_addr_log[255] !== 8'hFF || wr_data_log[255] !== 32'h1000_00FF) begin n_fail++; $display("FAIL full_last: got %02h/%08h want ff/100000ff", wr_addr_log[255], wr_data_log[255]); end
    n_checks++; if (dup_cnt !== 0) begin n_fail++; $display("FAIL full_dup: got %0d want 0", dup_cnt); end
  endtask

  task automatic test_stalls();
    int bad;
    do_reset();
    send_byte(8'h06, $urandom_range(0, 2)); send_byte(8'h00, $urandom_range(0, 2));
    for (int w = 1; w <= 6; w++) begin
      send_byte(8'(w), $urandom_range(0, 3));
      send_byte(8'h00, $urandom_range(0, 3));
      send_byte(8'h00, $urandom_range(0, 3));
      send_byte(8'h00, $urandom_range(0, 3));
    end
    repeat (3) @(negedge clk);
    n_checks++; if (wr_n !== 6) begin n_fail++; $display("FAIL stall_wr_count: got %0d want 6", wr_n); end
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (wr_addr_log[i] !== 8'(i) || wr_data_log[i] !== 32'(i + 1)) bad++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL stall_contents: got %0d bad entries want 0", bad); end
    n_checks++; if (dup_cnt !== 0) begin n_fail++; $display("FAIL stall_dup: got %0d want 0", dup_cnt); end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL stall_done: got %0b want 1", done); end
  endtask

  task automatic test_reset_during_write();
    do_reset();
    send_byte(8'h02, 0); send_byte(8'h00, 0);
    send_word(32'h1234_5678, 0);
    n_checks++; if (mem_we !== 1'b1 || mem_wdata !== 32'h1234_5678) begin n_fail++; $display("FAIL rdw_we_before: got %0b/%08h want 1/12345678", mem_we, mem_wdata); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rdw_we_dropped: got %0b want 0", mem_we); end
    n_checks++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL rdw_wdata: got %08h want 0", mem_wdata); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_word();
    do_reset();
    send_byte(8'h05, 0); send_byte(8'h00, 0);
    send_word(32'h1111_1111, 0);
    send_word(32'h2222_2222, 0);
    send_word(32'h3333_3333, 0);
    send_byte(8'h44, 0); send_byte(8'h44, 0);
    n_checks++; if (mem_addr !== 8'd2) begin n_fail++; $display("FAIL rmw_addr_before: got %02h want 02", mem_addr); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (mem_addr !== 8'd0 || mem_wdata !== 32'h0) begin n_fail++; $display("FAIL rmw_async_addr_data: got %02h/%08h want 00/0", mem_addr, mem_wdata); end
    n_checks++; if (in_ready !== 1'b1 || cpu_hold !== 1'b1) begin n_fail++; $display("FAIL rmw_async_ready_hold: got %0b/%0b want 1/1", in_ready, cpu_hold); end
    n_checks++; if (done !== 1'b0 || err !== 1'b0 || mem_we !== 1'b0) begin n_fail++; $display("FAIL rmw_async_flags: got done=%0b err=%0b we=%0b want 0/0/0", done, err, mem_we); end
    do_reset();
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'hEF, 0); send_byte(8'hBE, 0); send_byte(8'hAD, 0); send_byte(8'hDE, 0);
    @(posedge clk); #1;
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL rmw_done: got %0b want 1", done); end
    repeat (2) @(negedge clk);
    n_checks++; if (wr_n !== 1) begin n_fail++; $display("FAIL rmw_wr_count: got %0d want 1", wr_n); end
    n_checks++; if (wr_addr_log[0] !== 8'd0 || wr_data_log[0] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rmw_wr0: got %02h/%08h want 00/deadbeef", wr_addr_log[0], wr_data_log[0]); end
  endtask

  task automatic test_post_done();
    int wr_before;
    wr_before = wr_n;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'hAA;
    repeat (8) @(negedge clk);
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL post_ready: got %0b want 0", in_ready); end
    n_checks++; if (wr_n !== wr_before) begin n_fail++; $display("FAIL post_no_write: got %0d want %0d", wr_n, wr_before); end
    n_checks++; if (done !== 1'b1 || cpu_hold !== 1'b0) begin n_fail++; $display("FAIL post_done: got done=%0b hold=%0b want 1/0", done, cpu_hold); end
    in_valid = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic();
    test_zero_len();
    test_overflow();
    test_full_depth();
    test_stalls();
    test_reset_during_write();
    test_reset_mid_word();
    test_post_done();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the CPU instruction memory. Accepts a byte stream over a valid/ready handshake: a 16-bit word count followed by little-endian 32-bit instruction words. Each assembled word is written into instruction memory at consecutive word indices from 0. While loading, the block holds the fetch stage and PC register in reset through `cpu_hold`, and releases it once the last word is written.

## Interface
- `DEPTH`, 256: instruction memory depth in words.
- `ADDR_W`, 8: word-address width; DEPTH == 2**ADDR_W.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: `in_data` holds a valid byte.
- `in_data` input 8: stream byte.
- `in_ready` output 1: block accepts a byte this cycle. A handshake occurs when `in_valid && in_ready` at a rising edge.
- `mem_we` output 1: one-cycle write strobe to instruction memory.
- `mem_addr` output ADDR_W: word index. The fetch stage reads this with `pc[31:2]`.
- `mem_wdata` output 32: instruction word.
- `cpu_hold` output 1: high keeps the fetch/PC in reset. It is ORed externally with the CPU reset.
- `done` output 1: load completed successfully; sticky.
- `err` output 1: word count exceeded DEPTH; sticky.

## Operation
- State machine: LEN0, LEN1, DATA, FLUSH, DONE, ERR. All outputs are registered.
- Reset (async assert, sync release) values:
  - state = LEN0
  - `in_ready`=1, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `cpu_hold`=1, `done`=0, `err`=0
  - internal byte counter = 0, word index = 0, length = 0
- LEN0: on handshake, length[7:0] = byte, then go to LEN1.
- LEN1: on handshake, length[15:8] = byte, then branch on the full 16-bit length:
  - length == 0: go to DONE.
  - length > DEPTH: go to ERR.
  - otherwise: go to DATA.
- DATA byte handling:
  - Each handshake stores the byte into lane `byte_cnt` of the word shift register. Lane 0 is bits [7:0], so byte order is little-endian.
  - `byte_cnt` increments mod 4.
- DATA word completion, on the handshake with `byte_cnt`==3, the next cycle shows:
  - `mem_we`=1
  - `mem_addr` = word index
  - `mem_wdata` = the assembled 32-bit word
- DATA index advance: the word index increments after each write.
  - If the word just written was index length-1, go to FLUSH.
  - Otherwise stay in DATA.
- FLUSH: exactly one cycle, and `mem_we` is high during it. `in_ready`=0. Then go to DONE.
- DONE: `in_ready`=0, `cpu_hold`=0, `done`=1. Held until `rst_n` is asserted. Bytes offered here are ignored.
- ERR: `in_ready`=0, `cpu_hold`=1, `err`=1. Held until reset; no memory writes occur.
- `mem_we` is never high for more than one consecutive cycle per word.
- `mem_addr` and `mem_wdata` hold their last values when `mem_we`=0.
- Word index width is ADDR_W+1 so the comparison against length == DEPTH does not wrap.
- `in_valid` low stalls any state with no side effects. Partial words are kept indefinitely.

## Timing
- Throughput: 1 byte/cycle sustained. `in_ready` stays high in LEN0/LEN1/DATA, including the cycle `mem_we` is high.
- Write latency: `mem_we` rises 1 cycle after the 4th byte handshake of a word.
- Release latency: after the final word's 4th byte at edge E:
  - `mem_we`=1 during cycle E..E+1 (FLUSH).
  - `done`=1 and `cpu_hold`=0 from edge E+1.
  - The CPU therefore leaves reset only after the last write has completed.
- Zero-length load: `done`=1 and `cpu_hold`=0 one cycle after the LEN1 handshake.
- Reset mid-operation:
  - Asserting `rst_n` in any state immediately returns all outputs to reset values and `cpu_hold` to 1.
  - Any in-flight `mem_we` is dropped that same instant.
  - Partially written memory contents are not cleared. A new load starts at word 0.
- `err` rises one cycle after the LEN1 handshake.

## Test plan
- **Basic 2-word load**
  - Stimulus: back-to-back bytes 02 00, 01 00 00 00, 02 00 00 00.
  - Response: `mem_we` pulses at addr 0 with 0x00000001, then at addr 1 with 0x00000002. `done`=1 and `cpu_hold`=0 one cycle after the second pulse.
- **Zero length**
  - Stimulus: bytes 00 00.
  - Response: no `mem_we`; `done`=1 one cycle after the second byte; `in_ready`=0 afterwards.
- **Overflow**
  - Stimulus: bytes 01 01 (length 257, DEPTH=256).
  - Response: `err`=1, `cpu_hold` stays 1, `in_ready`=0, no writes. With length 256 (00 01), followed by 1024 data bytes, the last write is at addr 255 and `done`=1.
- **Stalls**
  - Stimulus: toggle `in_valid` randomly during a 6-word load of 0x00000001..0x00000006.
  - Response: identical writes in order; no duplicated or missing strobes.
- **Reset mid-word**
  - Stimulus: assert `rst_n` low after 2 bytes of word 3, then reload 1 word 0xDEADBEEF (bytes EF BE AD DE).
  - Response: outputs return to reset values asynchronously; write at addr 0 with 0xDEADBEEF; `done`=1.
- **Post-done input**
  - Stimulus: hold `in_valid`=1 with data after `done`.
  - Response: `in_ready`=0, no `mem_we`, `done` stays 1.
